// File: rtl/unidade_controle_jogo.sv
// Game control unit for the memory-sequence game.
// Moore FSM: state and every output are registered together, so the outputs
// always reflect the decode of the current state and fall to zero on reset.
module unidade_controle_jogo (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel,
    input  logic       fimS,
    input  logic       fimLedsOn,
    input  logic       fimLedsOff,
    input  logic       enderecoIgualSequencia,
    input  logic       jogadaIgualMemoria,
    input  logic       tem_jogada,
    input  logic       timeout,
    input  logic       meioE,
    input  logic       nivelChange,
    input  logic       memoriaChange,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       estado_espera,
    output logic       estado_ledsOn,
    output logic       estado_ledsOff,
    output logic       macro_exibicao,
    output logic       macro_jogadas,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        MOSTRA_LED        = 4'h2,
        APAGA_LED         = 4'h3,
        PROXIMO_LED       = 4'h4,
        INICIA_JOGADAS    = 4'h5,
        ESPERA_JOGADA     = 4'h6,
        REGISTRA          = 4'h7,
        COMPARA           = 4'h8,
        PROXIMA_JOGADA    = 4'h9,
        PROXIMA_SEQUENCIA = 4'hA,
        ACERTOU           = 4'hB,
        ERROU             = 4'hC,
        FIM_TIMEOUT       = 4'hD
    } stateT;

    // Bit positions of the registered output vector.
    localparam int ZE = 13, CE = 12, ZS = 11, CS = 10, ZR = 9, RR = 8;
    localparam int ESP = 7, LON = 6, LOFF = 5, MEX = 4, MJG = 3;
    localparam int PRT = 2, GAN = 1, PER = 0;

    stateT       state;
    logic [13:0] outReg;

    // Final round: 8 rounds end on address 7, 16 rounds on the sequence counter end.
    function automatic logic lastRound();
        return (!nivel && meioE) || (nivel && fimS);
    endfunction

    function automatic stateT nextState(input stateT cur);
        stateT nxt;
        nxt = cur;
        case (cur)
            INICIAL:           nxt = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        nxt = MOSTRA_LED;
            MOSTRA_LED:        nxt = fimLedsOn ? APAGA_LED : MOSTRA_LED;
            APAGA_LED:         if (fimLedsOff)
                                   nxt = enderecoIgualSequencia ? INICIA_JOGADAS : PROXIMO_LED;
            PROXIMO_LED:       nxt = MOSTRA_LED;
            INICIA_JOGADAS:    nxt = ESPERA_JOGADA;
            // timeout has priority over a simultaneous play
            ESPERA_JOGADA:     if (timeout)         nxt = FIM_TIMEOUT;
                               else if (tem_jogada) nxt = REGISTRA;
            REGISTRA:          nxt = COMPARA;
            COMPARA:           if (!jogadaIgualMemoria)          nxt = ERROU;
                               else if (!enderecoIgualSequencia) nxt = PROXIMA_JOGADA;
                               else if (lastRound())             nxt = ACERTOU;
                               else                              nxt = PROXIMA_SEQUENCIA;
            PROXIMA_JOGADA:    nxt = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: nxt = MOSTRA_LED;
            ACERTOU, ERROU, FIM_TIMEOUT:
                               nxt = iniciar ? PREPARACAO : cur;
            default:           nxt = INICIAL;
        endcase
        // A level or memory change aborts whatever game is in progress.
        if (cur != INICIAL && (nivelChange || memoriaChange))
            nxt = INICIAL;
        return nxt;
    endfunction

    function automatic logic [13:0] decodeOutputs(input stateT s);
        logic [13:0] o;
        o = '0;
        case (s)
            PREPARACAO:        begin o[ZE] = 1'b1; o[ZS] = 1'b1; o[ZR] = 1'b1; end
            MOSTRA_LED:        begin o[LON] = 1'b1; o[MEX] = 1'b1; end
            APAGA_LED:         begin o[LOFF] = 1'b1; o[MEX] = 1'b1; end
            PROXIMO_LED:       begin o[CE] = 1'b1; o[MEX] = 1'b1; end
            INICIA_JOGADAS:    begin o[ZE] = 1'b1; o[ZR] = 1'b1; o[MJG] = 1'b1; end
            ESPERA_JOGADA:     begin o[ESP] = 1'b1; o[MJG] = 1'b1; end
            REGISTRA:          begin o[RR] = 1'b1; o[MJG] = 1'b1; end
            COMPARA:           o[MJG] = 1'b1;
            PROXIMA_JOGADA:    begin o[CE] = 1'b1; o[MJG] = 1'b1; end
            PROXIMA_SEQUENCIA: begin o[CS] = 1'b1; o[ZE] = 1'b1; o[ZR] = 1'b1; end
            ACERTOU:           begin o[PRT] = 1'b1; o[GAN] = 1'b1; end
            ERROU, FIM_TIMEOUT: begin o[PRT] = 1'b1; o[PER] = 1'b1; end
            default:           o = '0;
        endcase
        return o;
    endfunction

    // State register with outputs registered from the decode of the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= INICIAL;
            outReg <= '0;
        end else begin
            state  <= nextState(state);
            outReg <= decodeOutputs(nextState(state));
        end
    end

    assign zeraE          = outReg[ZE];
    assign contaE         = outReg[CE];
    assign zeraS          = outReg[ZS];
    assign contaS         = outReg[CS];
    assign zeraR          = outReg[ZR];
    assign registraR      = outReg[RR];
    assign estado_espera  = outReg[ESP];
    assign estado_ledsOn  = outReg[LON];
    assign estado_ledsOff = outReg[LOFF];
    assign macro_exibicao = outReg[MEX];
    assign macro_jogadas  = outReg[MJG];
    assign pronto         = outReg[PRT];
    assign ganhou         = outReg[GAN];
    assign perdeu         = outReg[PER];
    assign db_estado      = state;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo: directed vector table plus
// hand-written game, timeout and asynchronous-reset sequences.
module tb_unidade_controle_jogo;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 0, nivel = 0, fimS = 0, fimLedsOn = 0, fimLedsOff = 0;
    logic enderecoIgualSequencia = 0, jogadaIgualMemoria = 0, tem_jogada = 0;
    logic timeout = 0, meioE = 0, nivelChange = 0, memoriaChange = 0;
    logic zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera;
    logic estado_ledsOn, estado_ledsOff, macro_exibicao, macro_jogadas;
    logic pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    int checks = 0;
    int failures = 0;

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .nivel(nivel), .fimS(fimS),
        .fimLedsOn(fimLedsOn), .fimLedsOff(fimLedsOff),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .jogadaIgualMemoria(jogadaIgualMemoria), .tem_jogada(tem_jogada),
        .timeout(timeout), .meioE(meioE), .nivelChange(nivelChange),
        .memoriaChange(memoriaChange), .zeraE(zeraE), .contaE(contaE),
        .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR), .registraR(registraR),
        .estado_espera(estado_espera), .estado_ledsOn(estado_ledsOn),
        .estado_ledsOff(estado_ledsOff), .macro_exibicao(macro_exibicao),
        .macro_jogadas(macro_jogadas), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Input masks: {iniciar,nivel,fimS,fimLedsOn,fimLedsOff,endIgual,jogIgual,tem,timeout,meioE,nivelCh,memCh}
    localparam logic [11:0] INI = 12'h800, NIV = 12'h400, FIMS = 12'h200, FLON = 12'h100;
    localparam logic [11:0] FLOFF = 12'h080, EIG = 12'h040, JIG = 12'h020, TEM = 12'h010;
    localparam logic [11:0] TMO = 12'h008, MEIO = 12'h004, NCH = 12'h002, MCH = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    // Output masks: {zeraE,contaE,zeraS,contaS,zeraR,registraR,espera,ledsOn,ledsOff,macroEx,macroJog,pronto,ganhou,perdeu}
    localparam logic [13:0] O_ZE = 14'h2000, O_CE = 14'h1000, O_ZS = 14'h0800, O_CS = 14'h0400;
    localparam logic [13:0] O_ZR = 14'h0200, O_RR = 14'h0100, O_ESP = 14'h0080, O_LON = 14'h0040;
    localparam logic [13:0] O_LOFF = 14'h0020, O_MEX = 14'h0010, O_MJG = 14'h0008;
    localparam logic [13:0] O_PRT = 14'h0004, O_GAN = 14'h0002, O_PER = 14'h0001;

    function automatic logic [13:0] expOuts(input logic [3:0] s);
        case (s)
            4'h1: return O_ZE | O_ZS | O_ZR;
            4'h2: return O_LON | O_MEX;
            4'h3: return O_LOFF | O_MEX;
            4'h4: return O_CE | O_MEX;
            4'h5: return O_ZE | O_ZR | O_MJG;
            4'h6: return O_ESP | O_MJG;
            4'h7: return O_RR | O_MJG;
            4'h8: return O_MJG;
            4'h9: return O_CE | O_MJG;
            4'hA: return O_CS | O_ZE | O_ZR;
            4'hB: return O_PRT | O_GAN;
            4'hC: return O_PRT | O_PER;
            4'hD: return O_PRT | O_PER;
            default: return 14'h0;
        endcase
    endfunction

    function automatic logic [13:0] actOuts();
        return {zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
                estado_ledsOn, estado_ledsOff, macro_exibicao, macro_jogadas,
                pronto, ganhou, perdeu};
    endfunction

    task automatic checkNow(input string name, input logic [3:0] expSt, input logic [13:0] expO);
        checks++;
        if (db_estado !== expSt) begin
            failures++;
            $display("FAIL %s state: got %h expected %h", name, db_estado, expSt);
        end
        checks++;
        if (actOuts() !== expO) begin
            failures++;
            $display("FAIL %s outputs: got %b expected %b", name, actOuts(), expO);
        end
    endtask

    // Apply one input vector for one clock edge, then check state and outputs.
    task automatic step(input logic [11:0] in, input logic [3:0] expSt, input string name);
        @(negedge clock);
        {iniciar, nivel, fimS, fimLedsOn, fimLedsOff, enderecoIgualSequencia,
         jogadaIgualMemoria, tem_jogada, timeout, meioE, nivelChange, memoriaChange} = in;
        @(posedge clock);
        #1;
        checkNow(name, expSt, expOuts(expSt));
    endtask

    // Plays an 8-round game (nivel=0) from preparacao; optionally misses one play.
    task automatic playGame(input int failRound, input int failPlay);
        step(NONE, 4'h2, "prep_to_show");
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i <= r; i++) begin
                step(FLON, 4'h3, "led_off");
                if (i < r) begin
                    step(FLOFF, 4'h4, "next_led");
                    step(NONE, 4'h2, "show_again");
                end else begin
                    step(FLOFF | EIG, 4'h5, "start_plays");
                    step(NONE, 4'h6, "wait_play");
                end
            end
            for (int j = 0; j <= r; j++) begin
                logic [11:0] in;
                logic [3:0]  ex;
                step(TEM, 4'h7, "register");
                step(NONE, 4'h8, "compare");
                if (r == failRound && j == failPlay) begin
                    step(EIG, 4'hC, "wrong_play");
                    return;
                end
                in = JIG | ((j == r) ? EIG : NONE) | ((j == 7) ? MEIO : NONE);
                ex = (j < r) ? 4'h9 : ((r == 7) ? 4'hB : 4'hA);
                step(in, ex, "compare_result");
                if (ex == 4'h9) step(NONE, 4'h6, "back_to_wait");
                if (ex == 4'hA) step(NONE, 4'h2, "next_round_show");
            end
        end
    endtask

    typedef struct {
        logic [11:0] in;
        logic [3:0]  st;
    } vecT;

    vecT vecs[$];

    initial begin
        // Table: starts from inicial right after reset release.
        vecs.push_back('{NONE, 4'h0});
        vecs.push_back('{INI, 4'h1});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{FLON, 4'h3});
        vecs.push_back('{NONE, 4'h3});
        vecs.push_back('{FLOFF | EIG, 4'h5});
        vecs.push_back('{NONE, 4'h6});
        vecs.push_back('{NONE, 4'h6});
        vecs.push_back('{TEM, 4'h7});
        vecs.push_back('{NONE, 4'h8});
        vecs.push_back('{JIG | EIG | NIV | MEIO, 4'hA});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{FLON, 4'h3});
        vecs.push_back('{FLOFF, 4'h4});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{FLON, 4'h3});
        vecs.push_back('{FLOFF | EIG, 4'h5});
        vecs.push_back('{NONE, 4'h6});
        vecs.push_back('{TEM, 4'h7});
        vecs.push_back('{NONE, 4'h8});
        vecs.push_back('{JIG, 4'h9});
        vecs.push_back('{NONE, 4'h6});
        vecs.push_back('{TEM, 4'h7});
        vecs.push_back('{NONE, 4'h8});
        vecs.push_back('{JIG | EIG | FIMS, 4'hA});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{MCH, 4'h0});
        vecs.push_back('{MCH, 4'h0});
        vecs.push_back('{INI, 4'h1});
        vecs.push_back('{NCH, 4'h0});
        vecs.push_back('{INI, 4'h1});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{FLON, 4'h3});
        vecs.push_back('{NCH | FLOFF | EIG, 4'h0});
        vecs.push_back('{INI, 4'h1});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{FLON, 4'h3});
        vecs.push_back('{FLOFF | EIG, 4'h5});
        vecs.push_back('{NONE, 4'h6});
        vecs.push_back('{TEM, 4'h7});
        vecs.push_back('{NONE, 4'h8});
        vecs.push_back('{JIG | EIG | NIV | FIMS, 4'hB});
        vecs.push_back('{NONE, 4'hB});
        vecs.push_back('{INI, 4'h1});
        vecs.push_back('{NONE, 4'h2});
        vecs.push_back('{MCH, 4'h0});

        // Reset held low: everything must read zero.
        #12;
        checkNow("reset_held", 4'h0, 14'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++)
            step(vecs[k].in, vecs[k].st, $sformatf("vec%0d", k));

        // Full 8-round win at nivel=0.
        step(INI, 4'h1, "win_start");
        playGame(-1, -1);
        step(NONE, 4'hB, "win_hold");

        // Round 3, second play wrong.
        step(INI, 4'h1, "lose_start");
        playGame(2, 1);
        step(NONE, 4'hC, "lose_hold");
        step(INI, 4'h1, "restart_after_loss");

        // Timeout and play in the same cycle: timeout wins.
        step(NONE, 4'h2, "to_show");
        step(FLON, 4'h3, "to_off");
        step(FLOFF | EIG, 4'h5, "to_start");
        step(NONE, 4'h6, "to_wait");
        step(TMO | TEM, 4'hD, "timeout_priority");
        step(TMO, 4'hD, "timeout_hold");
        step(INI, 4'h1, "restart_after_timeout");

        // Asynchronous reset mid-play, checked before the next rising edge.
        step(NONE, 4'h2, "ar_show");
        step(FLON, 4'h3, "ar_off");
        step(FLOFF | EIG, 4'h5, "ar_start");
        step(NONE, 4'h6, "ar_wait");
        #2;
        reset = 1'b0;
        #1;
        checkNow("async_reset_play", 4'h0, 14'h0);
        @(negedge clock);
        reset = 1'b1;
        step(NONE, 4'h0, "idle_after_reset");
        step(NONE, 4'h0, "idle_after_reset2");

        // Asynchronous reset mid-exhibition.
        step(INI, 4'h1, "ar2_start");
        step(NONE, 4'h2, "ar2_show");
        #2;
        reset = 1'b0;
        #1;
        checkNow("async_reset_show", 4'h0, 14'h0);
        @(negedge clock);
        reset = 1'b1;
        step(FLON, 4'h0, "idle_ignores_inputs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 SHALL provide port: clock  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide inputs (1 bit each): iniciar (start/restart request), nivel (0 = 8 rounds, 1 = 16 rounds), fimS, fimLedsOn, fimLedsOff, enderecoIgualSequencia, jogadaIgualMemoria, tem_jogada (one-cycle pulse), timeout (registered, sticky), meioE (address counter = 7), nivelChange, memoriaChange (one-cycle pulses).
REQ-004 SHALL provide datapath control outputs (1 bit each): zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera, estado_ledsOn, estado_ledsOff, macro_exibicao, macro_jogadas.
REQ-005 SHALL provide status outputs: pronto, ganhou, perdeu (1 bit each); db_estado (4 bits, current state code).

Function
REQ-006 SHALL be a Moore FSM; every output SHALL be decoded from the current state only.
REQ-007 SHALL use these state codes: 0 inicial, 1 preparacao, 2 mostra_led, 3 apaga_led, 4 proximo_led, 5 inicia_jogadas, 6 espera_jogada, 7 registra, 8 compara, 9 proxima_jogada, A proxima_sequencia, B acertou, C errou, D fim_timeout.
REQ-008 Codes E and F SHALL transition to inicial on the next clock edge.
REQ-009 inicial: all outputs 0; iniciar=1 -> preparacao.
REQ-010 preparacao: zeraE=zeraS=zeraR=1; -> mostra_led unconditionally.
REQ-011 mostra_led: estado_ledsOn=macro_exibicao=1; fimLedsOn -> apaga_led, else stay.
REQ-012 apaga_led: estado_ledsOff=macro_exibicao=1; on fimLedsOff, enderecoIgualSequencia -> inicia_jogadas, otherwise -> proximo_led; without fimLedsOff, stay.
REQ-013 proximo_led: contaE=macro_exibicao=1; -> mostra_led.
REQ-014 inicia_jogadas: zeraE=zeraR=macro_jogadas=1; -> espera_jogada.
REQ-015 espera_jogada: estado_espera=macro_jogadas=1; timeout -> fim_timeout; else tem_jogada -> registra; else stay.
REQ-016 If timeout and tem_jogada are both asserted in espera_jogada, timeout SHALL win.
REQ-017 registra: registraR=macro_jogadas=1; -> compara.
REQ-018 compara: macro_jogadas=1; !jogadaIgualMemoria -> errou; else if !enderecoIgualSequencia -> proxima_jogada; else if last round -> acertou; else -> proxima_sequencia.
REQ-019 The last-round condition SHALL be (nivel=0 and meioE) or (nivel=1 and fimS).
REQ-020 proxima_jogada: contaE=macro_jogadas=1; -> espera_jogada.
REQ-021 proxima_sequencia: contaS=zeraE=zeraR=1; -> mostra_led.
REQ-022 acertou: pronto=ganhou=1.
REQ-023 errou and fim_timeout: pronto=perdeu=1.
REQ-024 In acertou, errou and fim_timeout, iniciar -> preparacao; otherwise stay.
REQ-025 nivelChange or memoriaChange in any state other than inicial SHALL force inicial on the next edge; this SHALL override every other transition.
REQ-026 db_estado SHALL equal the current state code at all times.
REQ-027 Latency: a tem_jogada pulse SHALL reach compara exactly 2 edges later.

Reset
REQ-028 reset=0 SHALL force inicial immediately, without waiting for a clock edge, in any state, including mid-exhibition and mid-play.
REQ-029 While reset=0, all outputs SHALL be 0 and db_estado SHALL be 0.
REQ-030 After reset deasserts, the FSM SHALL stay in inicial until iniciar=1.

Verification
REQ-031 Scenario: reset, then iniciar pulse -> db_estado sequence 0,1,2; in state 1 zeraE=zeraS=zeraR=1; in state 2 estado_ledsOn=1.
REQ-032 Scenario: nivel=0 with datapath model, correct play for 8 rounds -> ends in state B with ganhou=pronto=1 and perdeu=0; no state A after the 8th compara.
REQ-033 Scenario: round 3, second play with jogadaIgualMemoria=0 -> state 8 then C, perdeu=1; then iniciar=1 -> state 1.
REQ-034 Scenario: state 6 with timeout=1 and tem_jogada=1 in the same cycle -> next state D, never 7.
REQ-035 Scenario: nivelChange pulse while in state 3 -> state 0 next edge; memoriaChange in state 0 -> remains 0.
REQ-036 Scenario: reset=0 asserted between edges while in state 6 -> db_estado=0 and estado_espera=0 before the next rising edge.
